// File: rtl/handshaking_fifo.sv
// handshaking_fifo
//   Synchronous valid/ready FIFO placed between a handshaking master and a
//   handshaking slave. It absorbs slave backpressure so the master can keep
//   issuing beats while the slave stalls. A beat transfers on a rising clk
//   edge when valid and ready are both high, on either side.
//
//   Optional feature: define HANDSHAKING_FIFO_BYPASS_EN to let a beat pass
//   straight through (zero latency, no write) when the FIFO is empty and
//   both the master and the slave are ready in the same cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   s_data_in    write data from the master
//   s_valid_in   write request from the master
//   s_ready_out  FIFO can accept a beat (low throughout reset)
//   m_data_out   head-of-FIFO data to the slave
//   m_valid_out  head entry valid
//   m_ready_in   slave accepts the head beat
//   count        number of occupied entries, 0..DEPTH
//   full         count == DEPTH
//   empty        count == 0
module handshaking_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data_in,
    input  logic                  s_valid_in,
    output logic                  s_ready_out,
    output logic [DATA_WIDTH-1:0] m_data_out,
    output logic                  m_valid_out,
    input  logic                  m_ready_in,
    output logic [ADDR_W:0]       count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [ADDR_W:0]       count_q;
    logic                  bypass;
    logic                  push;
    logic                  pop;

    assign count = count_q;
    assign full  = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty = (count_q == '0);

    // Ready depends only on reset and the registered count, never on
    // m_ready_in, so a pop while full does not admit a same-cycle push.
    assign s_ready_out = rst & ~full;

`ifdef HANDSHAKING_FIFO_BYPASS_EN
    // Empty FIFO with both sides ready: hand the beat straight across.
    assign bypass = rst & empty & s_valid_in & m_ready_in;
`else
    assign bypass = 1'b0;
`endif

    assign m_valid_out = ~empty | bypass;
    assign m_data_out  = bypass ? s_data_in : mem[rd_ptr];

    // A bypassed beat is neither written nor read from storage.
    assign push = s_valid_in & s_ready_out & ~bypass;
    assign pop  = ~empty & m_ready_in & ~bypass;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (ADDR_W+1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (ADDR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_handshaking_fifo.sv
// Self-checking bench for handshaking_fifo (default 8-bit x 4 configuration).
// A queue-based reference model predicts ready/valid/data/count each cycle.
module tb_handshaking_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

`ifdef HANDSHAKING_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data_in;
    logic          s_valid_in;
    logic          s_ready_out;
    logic [DW-1:0] m_data_out;
    logic          m_valid_out;
    logic          m_ready_in;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    handshaking_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data_in   (s_data_in),
        .s_valid_in  (s_valid_in),
        .s_ready_out (s_ready_out),
        .m_data_out  (m_data_out),
        .m_valid_out (m_valid_out),
        .m_ready_in  (m_ready_in),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    int unsigned   vectors     = 0;
    int unsigned   miscompares = 0;

    logic [DW-1:0] model_q [$];   // FIFO contents, head at index 0
    logic [DW-1:0] src [$];       // beats the master still has to send
    bit            known   = 1'b0;
    bit            did_push;
    bit [3:0]      pat     = 4'b1001;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are already driven (at the negedge). Check outputs, clock once,
    // advance the model, and return at the next negedge.
    task automatic step();
        bit exp_ready, exp_valid, byp, push, pop;
        logic [DW-1:0] exp_data;
        #1;
        byp       = BYP && rst && known && model_q.size() == 0 && s_valid_in && m_ready_in;
        exp_ready = rst && known && model_q.size() < DEPTH;
        exp_valid = known && (model_q.size() != 0 || byp);
        exp_data  = byp ? s_data_in : (model_q.size() != 0 ? model_q[0] : '0);
        push      = s_valid_in && exp_ready && !byp;
        pop       = known && model_q.size() != 0 && m_ready_in && !byp;

        check_eq("s_ready_out", 32'(s_ready_out), 32'(exp_ready));
        if (known) begin
            check_eq("count", 32'(count), 32'(model_q.size()));
            check_eq("full", 32'(full), 32'(model_q.size() == DEPTH));
            check_eq("empty", 32'(empty), 32'(model_q.size() == 0));
            check_eq("m_valid_out", 32'(m_valid_out), 32'(exp_valid));
            if (exp_valid) begin
                check_eq("m_data_out", 32'(m_data_out), 32'(exp_data));
            end
        end

        @(posedge clk);
        did_push = 1'b0;
        if (!rst) begin
            model_q.delete();
            known = 1'b1;
        end else if (byp) begin
            did_push = 1'b1;
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) begin
                model_q.push_back(s_data_in);
                did_push = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    // vmode: 0 idle, 1 always offer, 2 random offer
    // rmode: 0 stall, 1 always ready, 2 random, 3 pattern 1,0,0,1
    task automatic run(input int cycles, input int vmode, input int rmode, input bit rrand);
        for (int c = 0; c < cycles; c++) begin
            rst        = rrand ? ($urandom_range(0, 39) != 0) : 1'b1;
            s_valid_in = (src.size() != 0) &&
                         (vmode == 1 || (vmode == 2 && $urandom_range(0, 1) == 1));
            s_data_in  = (src.size() != 0) ? src[0] : DW'($urandom);
            case (rmode)
                0:       m_ready_in = 1'b0;
                1:       m_ready_in = 1'b1;
                2:       m_ready_in = ($urandom_range(0, 1) == 1);
                default: m_ready_in = pat[c % 4];
            endcase
            step();
            if (did_push) void'(src.pop_front());
        end
    endtask

    initial begin
        rst        = 1'b0;
        s_valid_in = 1'b0;
        s_data_in  = '0;
        m_ready_in = 1'b0;
        @(negedge clk);

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) step();

        // Single beat, then drain
        src = '{8'hA5};
        run(1, 1, 0, 1'b0);
        run(1, 0, 0, 1'b0);
        run(2, 0, 1, 1'b0);

        // Fill to full; fifth beat held until space appears
        src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run(6, 1, 0, 1'b0);
        run(10, 1, 1, 1'b0);

        // Simultaneous push and pop at count 2
        src = '{8'h30, 8'h31};
        run(2, 1, 0, 1'b0);
        src = '{8'h10};
        run(1, 1, 1, 1'b0);
        run(5, 0, 1, 1'b0);

        // Pointer wrap with continuous streaming
        src.delete();
        for (int i = 0; i < 16; i++) src.push_back(DW'(i));
        run(24, 1, 1, 1'b0);

        // Slave backpressure pattern
        for (int i = 0; i < 8; i++) src.push_back(DW'(8'h20 + i));
        run(28, 1, 3, 1'b0);

        // Mid-stream reset with three beats stored
        src = '{8'h40, 8'h41, 8'h42};
        run(3, 1, 0, 1'b0);
        rst        = 1'b0;
        s_valid_in = 1'b0;
        m_ready_in = 1'b1;
        step();
        run(4, 0, 1, 1'b0);

`ifdef HANDSHAKING_FIFO_BYPASS_EN
        // Zero-latency pass-through when empty
        src = '{8'h3C};
        run(1, 1, 1, 1'b0);
        run(2, 0, 1, 1'b0);
`endif

        // Randomized traffic with occasional resets
        src.delete();
        for (int i = 0; i < 400; i++) src.push_back(DW'($urandom));
        run(600, 2, 2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/handshaking_fifo.md
Name: handshaking_fifo

Overview:
- Synchronous valid/ready FIFO placed between the handshaking master output and the handshaking slave input.
- Absorbs backpressure so the master can keep issuing bytes while the slave stalls.
- Both sides use the same handshake as master/slave: a beat transfers on a rising clk edge when valid and ready are both high.
- Default configuration is 8-bit data, 4 entries.

Parameters:
- DATA_WIDTH, 8, width of each data beat.
- DEPTH, 4, number of storage entries. Must be a power of 2 and at least 2.
- ADDR_W, $clog2(DEPTH), pointer width. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset.
- s_data_in  input  DATA_WIDTH  write data from the master (master data_out).
- s_valid_in  input  1  write request from the master (master valid).
- s_ready_out  output  1  FIFO can accept a beat; drives master ready_in.
- m_data_out  output  DATA_WIDTH  head-of-FIFO data to the slave.
- m_valid_out  output  1  head entry valid; drives slave valid_in.
- m_ready_in  input  1  slave accepts the head beat (slave ready_out).
- count  output  ADDR_W+1  number of occupied entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset: sampled on posedge clk while rst==0.
  - Clears wr_ptr, rd_ptr and count to 0.
  - After the reset edge: empty=1, full=0, m_valid_out=0.
  - s_ready_out=0 in every cycle in which rst==0. It is 1 from the first cycle with rst==1.
  - Storage array is not reset.
  - Reset mid-operation discards all contents; no beat is delivered afterwards.
- push = s_valid_in & s_ready_out. Writes mem[wr_ptr] = s_data_in, then wr_ptr increments modulo DEPTH (natural wrap, ADDR_W bits).
- pop = m_valid_out & m_ready_in. rd_ptr increments modulo DEPTH.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: count unchanged, both pointers advance.
- s_ready_out = rst & ~full.
  - No combinational path from m_ready_in to s_ready_out.
  - When full, a simultaneous pop does not enable a same-cycle push; the push completes on the next cycle.
- m_valid_out = ~empty. m_data_out = mem[rd_ptr]. m_data_out is don't-care while m_valid_out==0.
- Latency: a beat pushed at edge N is visible on m_data_out/m_valid_out after edge N; the earliest pop is at edge N+1.
- Ordering is strict FIFO.
- No overflow or underflow is possible, because push and pop are gated by ready and valid.
- Stability: while m_valid_out==1 and m_ready_in==0, m_data_out and m_valid_out hold unchanged.
- full/empty/count are derived from the count register only. They are glitch-free and update only on clock edges.

Optional Feature:
- Macro HANDSHAKING_FIFO_BYPASS_EN.
- When defined: if empty==1, s_valid_in==1 and m_ready_in==1 in the same cycle, the beat passes through combinationally.
  - m_valid_out=1 and m_data_out=s_data_in.
  - The transfer completes on that edge with no write; pointers and count are unchanged.
  - Latency is 0 cycles. This adds a combinational path s_valid_in/s_data_in -> m_valid_out/m_data_out.
- When not defined: pure registered behaviour as above, minimum latency 1 cycle, no input-to-output combinational path.

Test Plan:
- Reset, then a single beat:
  - Hold rst=0 for 3 cycles: s_ready_out=0, m_valid_out=0, empty=1, count=0.
  - Release rst, push 0xA5 with m_ready_in=0: next cycle m_valid_out=1, m_data_out=0xA5, count=1.
- Fill to full:
  - m_ready_in=0, push 0x01,0x02,0x03,0x04: full=1, count=4, s_ready_out=0.
  - A fifth beat 0x05 is held by the master and not accepted.
  - Set m_ready_in=1: beats out in order 0x01..0x04, then 0x05 is accepted once s_ready_out=1.
- Simultaneous push/pop:
  - With count=2, drive push 0x10 and pop in the same cycle: count stays 2, output order preserved.
- Pointer wrap:
  - Stream 0x00..0x0F continuously with m_ready_in=1: all 16 bytes received in order, no loss or duplication, count never exceeds DEPTH.
- Slave backpressure:
  - Toggle m_ready_in 1,0,0,1 while the master streams 0x20..0x27: m_data_out stable during stalls, all 8 bytes delivered in order.
- Mid-stream reset:
  - With count=3, assert rst=0 for 1 cycle: count=0, empty=1, m_valid_out=0 afterwards, none of the old bytes delivered.
  - With HANDSHAKING_FIFO_BYPASS_EN defined, empty and both valid/ready high: input 0x3C appears on m_data_out in the same cycle, count remains 0.
